// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 8;
   localparam int LEN_BYTES          = 2;
   localparam int WORD_BYTES         = 4;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs payload bytes MSB-first into 32-bit words and keeps the running XOR of every byte.
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        strobe,
   input  logic [7:0]  data_byte,
   output logic [31:0] word,
   output logic        word_valid,
   output logic [7:0]  xor_sum
);

   localparam int LANE_W = $clog2(WORD_BYTES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

   logic [LANE_W-1:0] lane;

   always_ff @(posedge clk) begin
      if (rst) begin
         word       <= '0;
         word_valid <= 1'b0;
         xor_sum    <= '0;
         lane       <= '0;
      end else begin
         // word_valid lands in the cycle after the last lane so word is already complete
         word_valid <= strobe && (lane == LAST_LANE);
         if (clear) begin
            xor_sum <= '0;
            lane    <= '0;
         end else if (strobe) begin
            word    <= {word[23:0], data_byte};
            xor_sum <= xor_sum ^ data_byte;
            lane    <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory and
// releases the CPU from reset only after a fully verified load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_wdata,
   output logic                  cpu_rstn,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int LEN_W = LEN_BYTES * 8;
   localparam logic [LEN_W:0]   ONE_WORD  = 1;
   localparam logic [LEN_W:0]   MAX_WORDS = ONE_WORD << ADDR_WIDTH;
   localparam logic [LEN_W+1:0] ONE_BYTE  = 1;

   state_t state, state_next;

   logic [7:0]       len_hi;
   logic [LEN_W-1:0] len_words;
   logic [LEN_W+1:0] bytes_left;
   logic             len_ok;
   logic             hs;
   logic             clear;
   logic             strobe;
   logic [7:0]       xor_sum;

   assign hs        = rx_valid && rx_ready;
   assign len_words = {len_hi, rx_data};
   assign len_ok    = (len_words != '0) && ({1'b0, len_words} <= MAX_WORDS);
   assign strobe    = hs && (state == DATA);

   word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .strobe     (strobe),
      .data_byte  (rx_data),
      .word       (im_wdata),
      .word_valid (im_we),
      .xor_sum    (xor_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      rx_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      clear      = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            done = (state == DONE);
            err  = (state == ERR);
            if (start) begin
               state_next = LEN_HI;
               clear      = 1'b1;
            end
         end
         LEN_HI: begin
            rx_ready = 1'b1;
            if (hs) state_next = LEN_LO;
         end
         LEN_LO: begin
            rx_ready = 1'b1;
            if (hs) state_next = len_ok ? DATA : ERR;
         end
         DATA: begin
            rx_ready = 1'b1;
            if (hs && bytes_left == ONE_BYTE) state_next = CSUM;
         end
         CSUM: begin
            rx_ready = 1'b1;
            // xor_sum already includes the final payload byte even when this byte follows it directly
            if (hs) state_next = (rx_data == xor_sum) ? DONE : ERR;
         end
         default: state_next = IDLE;
      endcase
      busy = rx_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi     <= '0;
         bytes_left <= '0;
         im_addr    <= '0;
         cpu_rstn   <= 1'b0;
      end else begin
         // Registered from next state so the CPU release is a clean flop output aligned with DONE
         cpu_rstn <= (state_next == DONE);
         if (clear)
            im_addr <= '0;
         else if (im_we && im_addr != '1)
            im_addr <= im_addr + 1'b1;
         if (hs && state == LEN_HI)
            len_hi <= rx_data;
         if (hs && state == LEN_LO)
            bytes_left <= {2'b00, len_words} << $clog2(WORD_BYTES);
         else if (strobe)
            bytes_left <= bytes_left - ONE_BYTE;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams are scored against a stream-level
// model of the load protocol (length check, MSB-first word assembly, XOR checksum).
module tb_imem_loader;

   localparam int AW    = 8;
   localparam int DEPTH = 256;
   localparam int RES_DONE = 1;
   localparam int RES_ERR  = 2;

   typedef logic [7:0] bq_t [$];

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic          cpu_rstn;
   logic          busy;
   logic          done;
   logic          err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [AW-1:0] obs_addr [$];
   logic [31:0]   obs_data [$];
   logic [AW-1:0] exp_addr [$];
   logic [31:0]   exp_data [$];
   logic [31:0]   mem [0:DEPTH-1];
   logic          prev_we = 1'b0;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_rstn (cpu_rstn),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Memory-side observer: records every write strobe as the instruction memory would
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         check("we_single_cycle", prev_we, 1'b0);
         obs_addr.push_back(im_addr);
         obs_data.push_back(im_wdata);
         mem[im_addr] = im_wdata;
      end
      prev_we = (im_we === 1'b1);
   end

   // Reference: what a correct loader must write and how the session must end
   task automatic model(input bq_t s, output int res);
      int   n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      n = s[0] * 256 + s[1];
      if (n == 0 || n > DEPTH) begin
         res = RES_ERR;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(AW'(i));
         exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
         for (int k = 0; k < 4; k++) x = x ^ s[2+4*i+k];
      end
      res = (s[2+4*n] == x) ? RES_DONE : RES_ERR;
   endtask

   function automatic bq_t make_stream(input int n, input logic corrupt);
      bq_t  q;
      logic [7:0] x;
      logic [15:0] len;
      len = 16'(n);
      q.push_back(len[15:8]);
      q.push_back(len[7:0]);
      if (n == 0 || n > DEPTH) return q;
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         x = x ^ b;
         q.push_back(b);
      end
      if (corrupt) x = x ^ 8'($urandom_range(1, 255));
      q.push_back(x);
      return q;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      while ($urandom_range(99) < gap_pct) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      if (rx_ready !== 1'b1) begin
         check("rx_ready_in_session", rx_ready, 1'b1);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 1'b0);
      check({tag, "_im_we"},    im_we,    1'b0);
      check({tag, "_im_addr"},  im_addr,  '0);
      check({tag, "_im_wdata"}, im_wdata, '0);
      check({tag, "_cpu_rstn"}, cpu_rstn, 1'b0);
      check({tag, "_busy"},     busy,     1'b0);
      check({tag, "_done"},     done,     1'b0);
      check({tag, "_err"},      err,      1'b0);
   endtask

   task automatic run_session(input string tag, input bq_t s, input int gap_pct);
      int res;
      model(s, res);
      obs_addr.delete();
      obs_data.delete();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1'b1);
      foreach (s[i]) send_byte(s[i], gap_pct);
      // Result must be visible in the cycle right after the final handshake
      check({tag, "_done_now"}, done, res == RES_DONE);
      check({tag, "_err_now"},  err,  res == RES_ERR);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
      end
      check({tag, "_cpu_rstn"}, cpu_rstn, res == RES_DONE);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_rx_ready_end"}, rx_ready, 1'b0);
      check({tag, "_done_end"}, done, res == RES_DONE);
      check({tag, "_err_end"}, err, res == RES_ERR);
   endtask

   initial begin
      bq_t nominal;
      bq_t bad;
      bq_t s;
      // Payload XOR of 20 01 00 05 00 01 10 80 is B5
      nominal = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'h10, 8'h80, 8'hB5};
      bad     = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'h10, 8'h80, 8'h00};

      rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", busy, 1'b0);

      run_session("nominal", nominal, 0);
      run_session("bad_csum", bad, 0);
      run_session("len_zero", make_stream(0, 1'b0), 0);
      run_session("len_257", make_stream(257, 1'b0), 0);
      run_session("gaps", nominal, 40);
      run_session("len_one", make_stream(1, 1'b0), 20);
      run_session("len_max", make_stream(DEPTH, 1'b0), 10);
      for (int k = 0; k < 8; k++) begin
         s = make_stream($urandom_range(1, 8), 1'($urandom_range(0, 1)));
         run_session($sformatf("rand%0d", k), s, 30);
      end

      // Abort in the middle of the second word
      obs_addr.delete();
      obs_data.delete();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) send_byte(nominal[i], 0);
      rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h10; start = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("mid_rst");
      rst = 1'b0; rx_valid = 1'b0; start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid_rst_nwrites", obs_addr.size(), 1);
      if (obs_data.size() > 0) check("mid_rst_word0", obs_data[0], 32'h20010005);
      check("mid_rst_still_idle", busy, 1'b0);

      // Failed load keeps the CPU held; a later good load releases it onto the new image
      mem[0] = 32'hDEADBEEF;
      run_session("reload_bad", bad, 0);
      check("reload_held", cpu_rstn, 1'b0);
      run_session("reload_good", nominal, 15);
      check("reload_released", cpu_rstn, 1'b1);
      check("reload_fetch_pc0", mem[0], 32'h20010005);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
